aes_inv_sub_shift: RTL and testbench

AES_INV_SUB_SHIFT -- requirements
Module: aes_inv_sub_shift

---
 rtl/aes_inv_sub_shift.sv | 98 +++++++++
 tb/tb_aes_inv_sub_shift.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_sub_shift.sv
// Inverse SubBytes on one AES state, optionally preceded by InvShiftRows.
// One byte is substituted per cycle through a single shared inverse S-box.
//  state | meaning
//  IDLE  | waiting for an input block (in_ready high)
//  BUSY  | substituting working byte cnt
//  DONE  | result held on out_data until taken
module aes_inv_sub_shift #(
  parameter int SHIFT_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  logic [1:0] state;
  logic [3:0] cnt;
  logic [7:0] work [16];
  logic [7:0] load [16];

  // Byte k of the state sits at row k%4, column k/4; rows rotate right by r.
  always_comb begin
    for (int k = 0; k < 16; k++) load[k] = 8'h00;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (SHIFT_EN != 0)
          load[r + 4 * ((c + r) % 4)] = in_data[127 - 8 * (r + 4 * c) -: 8];
        else
          load[r + 4 * c] = in_data[127 - 8 * (r + 4 * c) -: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      for (int k = 0; k < 16; k++) work[k] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < 16; k++) work[k] <= load[k];
            cnt   <= 4'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          work[cnt] <= INV_SBOX[work[cnt]];
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 16; k++) out_data[127 - 8 * k -: 8] = work[k];
  end

endmodule

// File: tb/tb_aes_inv_sub_shift.sv
// Bench for aes_inv_sub_shift: shifted and plain instances side by side,
// checked against a GF(2^8)-derived inverse S-box model.
module tb_aes_inv_sub_shift;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;
  logic         in_ready_s, out_valid_s, busy_s;
  logic         in_ready_p, out_valid_p, busy_p;
  logic [127:0] out_data_s, out_data_p;

  int checks = 0;
  int errors = 0;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  aes_inv_sub_shift #(.SHIFT_EN(1)) u_shift (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .busy(busy_s));

  aes_inv_sub_shift #(.SHIFT_EN(0)) u_plain (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
    .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p), .busy(busy_p));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Forward S-box = affine(GF inverse); the inverse table is its inversion.
  task automatic build_tables();
    logic [7:0] v, s;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] d, input bit shift);
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [127:0] o = '0;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = d[127 - 8 * k -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (shift) t[r][(c + r) % 4] = m[r][c];
        else       t[r][c] = m[r][c];
    for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = inv_tab[t[k % 4][k / 4]];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a falling edge with both instances idle.
  task automatic run_block(input logic [127:0] data, input logic [127:0] exp_s,
                           input logic [127:0] exp_p, input logic rdy, input logic noise,
                           input string tag);
    int n, nb;
    chk({tag, ":in_ready"}, 128'({in_ready_s, in_ready_p}), 128'd3);
    out_ready = rdy;
    in_valid  = 1'b1;
    in_data   = data;
    @(negedge clk);
    n  = 1;
    nb = 0;
    in_valid = 1'b0;
    while (!out_valid_s && n < 40) begin
      if (busy_s) nb++;
      if (noise) begin
        in_valid = 1'b1;
        in_data  = rnd128();
      end
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk({tag, ":latency"}, 128'(n), 128'd17);
    chk({tag, ":busy_cycles"}, 128'(nb), 128'd16);
    chk({tag, ":out_valid_p"}, 128'(out_valid_p), 128'd1);
    chk({tag, ":data_shift"}, out_data_s, exp_s);
    chk({tag, ":data_plain"}, out_data_p, exp_p);
    if (rdy) begin
      @(negedge clk);
      chk({tag, ":back_idle"}, 128'({in_ready_s, in_ready_p, out_valid_s, out_valid_p}), 128'b1100);
    end
  endtask

  logic [127:0] d, es, ep;

  initial begin
    build_tables();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst:flags_s", 128'({in_ready_s, out_valid_s, busy_s}), 128'b100);
    chk("rst:flags_p", 128'({in_ready_p, out_valid_p, busy_p}), 128'b100);
    chk("rst:data_s", out_data_s, 128'h0);
    chk("rst:data_p", out_data_p, 128'h0);
    rst = 1'b0;

    run_block({16{8'h63}}, 128'h0, 128'h0, 1'b1, 1'b0, "all63");
    run_block({16{8'h00}}, {16{8'h52}}, {16{8'h52}}, 1'b1, 1'b0, "all00");
    run_block({16{8'h16}}, {16{8'hff}}, {16{8'hff}}, 1'b1, 1'b0, "all16");
    run_block(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000d0a0704010e0b0805020f0c090603,
              128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, "vector");

    // Backpressure in DONE with a competing input offered every cycle.
    d  = rnd128();
    es = ref_model(d, 1'b1);
    ep = ref_model(d, 1'b0);
    run_block(d, es, ep, 1'b0, 1'b0, "hold");
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = rnd128();
      @(negedge clk);
      chk("hold:stable_s", out_data_s, es);
      chk("hold:stable_p", out_data_p, ep);
      chk("hold:flags", 128'({out_valid_s, in_ready_s, busy_s}), 128'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hold:release", 128'({in_ready_s, out_valid_s, in_ready_p, out_valid_p}), 128'b1010);
    chk("hold:no_capture", out_data_s, es);

    // Reset while substituting byte 7.
    in_valid = 1'b1;
    in_data  = rnd128();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst:busy", 128'({busy_s, busy_p}), 128'b11);
    rst = 1'b1;
    #1;
    chk("midrst:flags", 128'({in_ready_s, out_valid_s, busy_s, in_ready_p, out_valid_p, busy_p}), 128'b100100);
    chk("midrst:data_s", out_data_s, 128'h0);
    chk("midrst:data_p", out_data_p, 128'h0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst:held", 128'({in_ready_s, out_valid_s}), 128'b10);
    rst = 1'b0;
    d = rnd128();
    run_block(d, ref_model(d, 1'b1), ref_model(d, 1'b0), 1'b1, 1'b0, "after_rst");

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = rnd128();
      run_block(d, ref_model(d, 1'b1), ref_model(d, 1'b0), 1'b1, 1'(i % 2), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
